ram_access_ctrl: RTL and testbench
==================================

// Module: ram_access_ctrl
// PURPOSE
//  Sequences every access to the 16x8 program/data RAM and shares it between two requesters:
//  port A (CPU fetch/execute) and port B (program loader / debug).
//  Owns the RAM address, the read/write enables and the controller's tri-state drive onto the shared 8-bit bus.
//  Sits between the control unit / loader and the RAM, replacing direct MAR-to-RAM enable wiring.
// PARAMETERS
//  WIDTH  8  data/bus width in bits
//  AW     4  RAM address width (16 locations)
// PORTS
//  clk        in     1      system clock, all state updates on posedge
//  rst_n      in     1      asynchronous, active-low reset
//  a_req      in     1      port A request; held high until a_done
//  a_we       in     1      port A: 1 = write, 0 = read; sampled at grant
//  a_addr     in     AW     port A address; sampled at grant
//  a_wdata    in     WIDTH  port A write data; sampled at grant
//  a_gnt      out    1      port A owns the RAM (GRANT..DONE)
//  a_done     out    1      one-cycle completion pulse for port A
//  a_rdata    out    WIDTH  port A read data, valid from a_done until next A read
//  b_req/b_we/b_addr/b_wdata/b_gnt/b_done/b_rdata  same as port A, for port B
//  ram_addr   out    AW     RAM address
//  ram_rd_en  out    1      RAM read enable (RAM drives bus)
//  ram_wr_en  out    1      RAM write enable (RAM captures bus on posedge)
//  bus        inout  WIDTH  shared data bus; controller drives only during a write XFER
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all outputs 0; rdata regs 0; bus=Z;
//   last-grant = B, so A wins the first tie. Takes effect immediately, mid-transaction included;
//   an interrupted write is not committed unless its posedge already occurred.
//  FSM: IDLE -> GRANT -> XFER -> DONE -> IDLE. One access per 4 cycles; no back-to-back pipelining.
//  IDLE:  if any req, pick the winner and go to GRANT. Otherwise stay in IDLE.
//  GRANT: latch the winner's we/addr/wdata; gnt(winner)=1; ram_addr=latched addr; no enables.
//  XFER, read:  ram_rd_en=1; bus left Z by the controller; rdata(winner) <= bus at the closing posedge.
//  XFER, write: bus=latched wdata; ram_wr_en=1; RAM stores at the closing posedge.
//  DONE:  done(winner)=1 for exactly this cycle; gnt stays 1; enables 0; bus Z. Next state is IDLE.
//  Latency: req high at posedge N (in IDLE) -> gnt at N+1, XFER at N+2, done at N+3.
//   A req still high at N+4 starts a new access.
//  Arbitration is round-robin on simultaneous reqs: grant the port not granted last.
//   A single requester always wins. last-grant updates on IDLE->GRANT.
//  Requester inputs after grant are ignored. Dropping req mid-access does not abort it; done still pulses.
//  ram_rd_en and ram_wr_en are never both 1.
//  The controller never drives bus while ram_rd_en=1 (no contention).
//  Address wrap is not applicable: full AW-bit address is passed through; 4'hF is valid.
//  All outputs are registered except bus, which is a combinational tri-state from registered state/wdata.
// STRUCTURE
//  Package ram_ctrl_pkg: state enum {IDLE,GRANT,XFER,DONE}; WIDTH/AW defaults; PORT_A/PORT_B constants.
//  Sub-module rr_arb2: 2-input round-robin arbiter (req[1:0], last, advance -> gnt onehot).
//  FSM, latches and bus driver live in the top module.
// TESTING
//  1. A write 0x5A @4'h3, then A read @4'h3 -> ram_wr_en 1 cycle with bus=0x5A; later a_rdata=0x5A.
//     Each a_done arrives 3 cycles after req is sampled.
//  2. a_req and b_req rise on the same edge after reset -> A granted first, then B.
//     Both still requesting -> strict A,B,A,B alternation.
//  3. B write 0xFF @4'hF, B read @4'hF -> b_rdata=0xFF; boundary address correct; a_* outputs stay 0.
//  4. Drop a_req during XFER -> a_done still pulses once. No new grant while req=0.
//  5. Assert rst_n=0 during write XFER, before the posedge -> enables 0, bus Z, state IDLE at once.
//     Readback shows the old content.
//  6. Every cycle, assertions check: rd_en&wr_en never both 1; bus driven only when ram_wr_en=1;
//     gnt is one-hot-or-zero; each done is 1 cycle.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM access controller.
//   state_e       : access sequencer states (idle, grant, transfer, done)
//   DEF_WIDTH     : default data/bus width
//   DEF_AW        : default RAM address width
//   PORT_A/PORT_B : requester identifiers, also the bit index of each port in a grant vector
package ram_ctrl_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_AW    = 4;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StXfer,
    StDone
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with its own last-grant memory.
//   clk, rst_n : clock, asynchronous active-low reset (last-grant resets to port B)
//   req[1:0]   : requests, bit 0 = port A, bit 1 = port B
//   advance    : commit the current grant as the new last-grant
//   gnt[1:0]   : one-hot (or zero) combinational grant
module rr_arb2
  import ram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_q;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // On a tie the port that was not served last wins.
      2'b11:   gnt = (last_q == PORT_A) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= PORT_B;
    end else if (advance && (|gnt)) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Sequences every access to the 16x8 RAM and shares it between port A (CPU) and port B (loader).
// Each access runs idle -> grant -> transfer -> done, one access per four cycles.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata  : port A request, sampled when the grant is taken
//   a_gnt/a_done/a_rdata       : port A ownership, one-cycle completion pulse, read data
//   b_*                        : same for port B
//   ram_addr/ram_rd_en/ram_wr_en : RAM address and enables
//   bus                        : shared data bus, driven here only during a write transfer
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned AW    = DEF_AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_req,
  input  logic             a_we,
  input  logic [AW-1:0]    a_addr,
  input  logic [WIDTH-1:0] a_wdata,
  output logic             a_gnt,
  output logic             a_done,
  output logic [WIDTH-1:0] a_rdata,
  input  logic             b_req,
  input  logic             b_we,
  input  logic [AW-1:0]    b_addr,
  input  logic [WIDTH-1:0] b_wdata,
  output logic             b_gnt,
  output logic             b_done,
  output logic [WIDTH-1:0] b_rdata,
  output logic [AW-1:0]    ram_addr,
  output logic             ram_rd_en,
  output logic             ram_wr_en,
  inout  wire  [WIDTH-1:0] bus
);

  state_e           state_q;
  logic             win_q;
  logic             we_q;
  logic [WIDTH-1:0] wdata_q;
  logic [1:0]       arb_gnt;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({b_req, a_req}),
    .advance (state_q == StIdle),
    .gnt     (arb_gnt)
  );

  // ram_wr_en is only ever set in the transfer state of a write, and it drops asynchronously on
  // reset, so the bus is released the moment reset asserts.
  assign bus = ram_wr_en ? wdata_q : {WIDTH{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      win_q     <= PORT_A;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      a_gnt     <= 1'b0;
      b_gnt     <= 1'b0;
      a_done    <= 1'b0;
      b_done    <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
      ram_addr  <= '0;
      ram_rd_en <= 1'b0;
      ram_wr_en <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Latch the winner's request here so ram_addr is already valid during the grant cycle.
          if (|arb_gnt) begin
            state_q  <= StGrant;
            win_q    <= arb_gnt[1];
            we_q     <= arb_gnt[1] ? b_we : a_we;
            wdata_q  <= arb_gnt[1] ? b_wdata : a_wdata;
            ram_addr <= arb_gnt[1] ? b_addr : a_addr;
            a_gnt    <= arb_gnt[0];
            b_gnt    <= arb_gnt[1];
          end
        end
        StGrant: begin
          state_q   <= StXfer;
          ram_rd_en <= !we_q;
          ram_wr_en <= we_q;
        end
        StXfer: begin
          state_q   <= StDone;
          ram_rd_en <= 1'b0;
          ram_wr_en <= 1'b0;
          if (!we_q) begin
            if (win_q == PORT_B) b_rdata <= bus;
            else                 a_rdata <= bus;
          end
          a_done <= (win_q == PORT_A);
          b_done <= (win_q == PORT_B);
        end
        StDone: begin
          state_q  <= StIdle;
          a_done   <= 1'b0;
          b_done   <= 1'b0;
          a_gnt    <= 1'b0;
          b_gnt    <= 1'b0;
          ram_addr <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-timeline model of the controller and a shadow memory.
module tb_ram_access_ctrl;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [3:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_wdata = '0, b_wdata = '0;
  logic       a_gnt, a_done, b_gnt, b_done;
  logic [7:0] a_rdata, b_rdata;
  logic [3:0] ram_addr;
  logic       ram_rd_en, ram_wr_en;
  wire  [7:0] bus;

  // Physical RAM attached to the controller.
  logic [7:0] mem [16];
  assign bus = ram_rd_en ? mem[ram_addr] : 8'bz;
  always @(posedge clk) if (ram_wr_en) mem[ram_addr] <= bus;

  ram_access_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_gnt     (a_gnt),
    .a_done    (a_done),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_gnt     (b_gnt),
    .b_done    (b_done),
    .b_rdata   (b_rdata),
    .ram_addr  (ram_addr),
    .ram_rd_en (ram_rd_en),
    .ram_wr_en (ram_wr_en),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: ph counts cycles into the current access (0 = no access in progress).
  int         ph = 0;
  logic       m_win = 1'b0, m_last = 1'b1, m_we = 1'b0;
  logic [3:0] m_addr = '0;
  logic [7:0] m_wdata = '0;
  logic [7:0] exp_mem [16];
  logic [7:0] exp_rd [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    ph        = 0;
    m_last    = 1'b1;
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
  endtask

  // Advance the model by one clock edge using the inputs presented at that edge.
  task automatic model_edge();
    case (ph)
      0: if (a_req || b_req) begin
        m_win   = (a_req && b_req) ? !m_last : b_req;
        m_last  = m_win;
        m_we    = m_win ? b_we : a_we;
        m_addr  = m_win ? b_addr : a_addr;
        m_wdata = m_win ? b_wdata : a_wdata;
        ph      = 1;
      end
      1: ph = 2;
      2: begin
        if (m_we) exp_mem[m_addr] = m_wdata;
        else      exp_rd[m_win]   = exp_mem[m_addr];
        ph = 3;
      end
      default: ph = 0;
    endcase
  endtask

  task automatic check_outputs();
    chk("a_gnt",   a_gnt,     ph != 0 && !m_win);
    chk("b_gnt",   b_gnt,     ph != 0 &&  m_win);
    chk("a_done",  a_done,    ph == 3 && !m_win);
    chk("b_done",  b_done,    ph == 3 &&  m_win);
    chk("rd_en",   ram_rd_en, ph == 2 && !m_we);
    chk("wr_en",   ram_wr_en, ph == 2 &&  m_we);
    chk("rd_wr_excl", ram_rd_en & ram_wr_en, 0);
    chk("a_rdata", a_rdata,   exp_rd[0]);
    chk("b_rdata", b_rdata,   exp_rd[1]);
    if (ph != 0) chk("ram_addr", ram_addr, m_addr);
    if (ph == 2 && m_we) chk("bus_wdata", bus, m_wdata);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic rand_ops();
    a_we = 1'($urandom); a_addr = 4'($urandom); a_wdata = 8'($urandom);
    b_we = 1'($urandom); b_addr = 4'($urandom); b_wdata = 8'($urandom);
  endtask

  // Called at a negedge; reset asserts mid-cycle, away from the clock edge.
  task automatic apply_reset();
    #2 rst_n = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
    #1 model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    a_req = 1'b0;
    b_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (ph == 0) break;
      step();
    end
  endtask

  task automatic do_access(input logic port, input logic we, input logic [3:0] addr,
                           input logic [7:0] wdata, output int lat);
    a_req = !port; b_req = port;
    if (port) begin b_we = we; b_addr = addr; b_wdata = wdata; end
    else      begin a_we = we; a_addr = addr; a_wdata = wdata; end
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      lat++;
      if (port ? b_done : a_done) break;
    end
    a_req = 1'b0;
    b_req = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int         lat;
    int         ndone;
    logic       exp_port;
    logic [7:0] old;

    for (int i = 0; i < 16; i++) begin
      mem[i]     = 8'($urandom);
      exp_mem[i] = mem[i];
    end
    model_reset();
    #1 rst_n = 1'b0;
    #2 check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // B write/read at the top address; port A stays idle.
    do_access(1'b1, 1'b1, 4'hF, 8'hFF, lat);
    chk("t3_wr_latency", lat, 3);
    do_access(1'b1, 1'b0, 4'hF, 8'h00, lat);
    chk("t3_b_rdata", b_rdata, 8'hFF);
    chk("t3_a_rdata", a_rdata, 8'h00);

    // A write 0x5A @3 then read it back.
    do_access(1'b0, 1'b1, 4'h3, 8'h5A, lat);
    chk("t1_wr_latency", lat, 3);
    do_access(1'b0, 1'b0, 4'h3, 8'h00, lat);
    chk("t1_rd_latency", lat, 3);
    chk("t1_a_rdata", a_rdata, 8'h5A);

    // Simultaneous requests after reset alternate A,B,A,B.
    apply_reset();
    rand_ops();
    a_req    = 1'b1;
    b_req    = 1'b1;
    exp_port = 1'b0;
    ndone    = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      rand_ops();
      if (a_done || b_done) begin
        chk("t2_order", {a_done, b_done}, exp_port ? 2'b01 : 2'b10);
        exp_port = !exp_port;
        ndone++;
      end
    end
    chk("t2_count", ndone, 4);
    drain();

    // Drop a_req during the transfer; done still pulses, no regrant.
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'h3;
    step();
    step();
    chk("t4_in_xfer", ram_rd_en, 1);
    a_req = 1'b0;
    step();
    chk("t4_done", a_done, 1);
    step();
    step();
    chk("t4_no_regrant", a_gnt, 0);

    // Randomized traffic on both ports.
    for (int i = 0; i < 1500; i++) begin
      a_req = ($urandom_range(0, 2) != 0);
      b_req = ($urandom_range(0, 2) != 0);
      rand_ops();
      step();
    end
    drain();

    // Reset in the middle of a write transfer: nothing is committed.
    old   = exp_mem[7];
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'h7; a_wdata = ~old;
    b_req = 1'b0;
    step();
    step();
    chk("t5_in_xfer", ram_wr_en, 1);
    apply_reset();
    do_access(1'b0, 1'b0, 4'h7, 8'h00, lat);
    chk("t5_old_content", a_rdata, old);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
